reg_bank_slave: RTL and testbench
=================================

REG_BANK_SLAVE -- requirements
Module: reg_bank_slave

Interface
REQ-001 Parameter DATA_W, default 8: register and data width in bits, 1..64.
REQ-002 Parameter ADDR_W, default 2: request address width in bits, 1..8.
REQ-003 Parameter NUM_REGS, default 4: implemented registers; the block SHALL require 1 <= NUM_REGS <= 2**ADDR_W.
REQ-004 Parameter WAIT_CYCLES, default 1: wait states inserted per transaction, 0..15.
REQ-005 Parameter RESET_VAL, default 0: DATA_W-bit reset value loaded into every register.
REQ-006 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-007 rstn  input  1  asynchronous, active-low reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block accepts a request this cycle.
REQ-010 req_write  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_W  register index.
REQ-012 req_wdata  input  DATA_W  write data.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-016 rsp_err  output  1  address out of range.
REQ-017 reg_q  output  NUM_REGS*DATA_W  flat register contents; register i SHALL occupy bits [i*DATA_W +: DATA_W].

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-019 req_ready SHALL be 1 in IDLE only and SHALL be decoded from the registered state, with no combinational path from any input.
REQ-020 A request SHALL be accepted on a rising edge where req_valid && req_ready; req_write, req_addr and req_wdata SHALL be captured on that edge.
REQ-021 On accept, the FSM SHALL go IDLE->RESP when WAIT_CYCLES==0, and IDLE->WAIT otherwise, loading a 4-bit wait counter with WAIT_CYCLES.
REQ-022 In WAIT, the counter SHALL decrement every cycle, and the FSM SHALL go WAIT->RESP on the edge where the counter equals 1.
REQ-023 The register access SHALL commit on the edge that enters RESP, WAIT_CYCLES edges after the accept edge.
REQ-024 On that same edge, rsp_valid, rsp_rdata and rsp_err SHALL be registered, so rsp_valid first goes high WAIT_CYCLES+1 cycles after accept.
REQ-025 In RESP, rsp_valid SHALL stay 1, and rsp_rdata and rsp_err SHALL stay stable, until rsp_valid && rsp_ready on a rising edge.
REQ-026 On that response handshake edge, the FSM SHALL go RESP->IDLE and rsp_valid SHALL drop to 0.
REQ-027 A new request SHALL be accepted no earlier than the edge after the response handshake; peak rate SHALL be one transaction per WAIT_CYCLES+2 cycles.
REQ-028 A write with req_addr < NUM_REGS SHALL load req_wdata into register req_addr; rsp_rdata=0 and rsp_err=0.
REQ-029 A read with req_addr < NUM_REGS SHALL return the register value at the commit edge; rsp_err=0.
REQ-030 When req_addr >= NUM_REGS, no register SHALL change, and the response SHALL carry rsp_err=1 and rsp_rdata=0.
REQ-031 reg_q SHALL reflect a write on the commit edge itself, with no extra delay.
REQ-032 Outside IDLE, req_valid and all req_* inputs SHALL be ignored, and captured values SHALL be immune to input changes after accept.
REQ-033 While in WAIT, rsp_ready SHALL have no effect.
REQ-034 rsp_ready held high continuously SHALL be legal and SHALL complete each response in a single RESP cycle.

Reset
REQ-035 Assertion of rstn=0 SHALL immediately, without waiting for clk, force: state IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, and every register to RESET_VAL.
REQ-036 Any in-flight transaction SHALL be dropped by reset: no commit and no response; an uncommitted write SHALL leave registers at RESET_VAL.
REQ-037 After rstn deasserts, the first accept SHALL be possible on the first rising edge with rstn=1; req_ready SHALL be 1 during that cycle.

Verification
REQ-038 Defaults: reset, then write addr 2 data 0xA5 with rsp_ready=1 -> rsp_valid high 2 cycles after accept, rsp_err=0, reg_q[23:16]=0xA5; read addr 2 -> rsp_rdata=0xA5.
REQ-039 Write then read each of addresses 0..3 with data addr*4 -> reads return 0x00, 0x04, 0x08, 0x0C; no cross-register corruption.
REQ-040 Set WAIT_CYCLES=0 and NUM_REGS=3; write addr 3 data 0xFF -> rsp_err=1, rsp_rdata=0, reg_q unchanged; response one cycle after accept.
REQ-041 Set WAIT_CYCLES=3; hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid stable, req_ready=0 throughout, req_valid pulses ignored; the handshake completes on rsp_ready=1.
REQ-042 Assert rstn=0 mid-WAIT during a write of 0x3C to addr 1 -> outputs clear asynchronously, reg_q[15:8]=RESET_VAL, and no rsp_valid after reset release.

Source files
------------

// File: rtl/reg_bank_slave.sv
// rtl/reg_bank_slave.sv - register bank slave with req/rsp handshake and programmable wait states
module reg_bank_slave #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 2,
    parameter int                NUM_REGS    = 4,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic [NUM_REGS*DATA_W-1:0] reg_q
);

    if (NUM_REGS < 1 || NUM_REGS > (1 << ADDR_W)) begin : g_bad_num_regs
        $error("reg_bank_slave: NUM_REGS must be in 1..2**ADDR_W");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0]      WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    state_t              state;
    logic [3:0]          wait_cnt;
    logic                cap_write;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic                accept;
    logic                commit;
    logic                c_write;
    logic                c_in_range;
    logic [ADDR_W-1:0]   c_addr;
    logic [DATA_W-1:0]   c_wdata;
    logic [DATA_W-1:0]   c_rdata;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    // With zero wait states the access commits on the accept edge, so it uses the live request.
    always_comb begin
        c_write = cap_write;
        c_addr  = cap_addr;
        c_wdata = cap_wdata;
        commit  = 1'b0;
        if (state == IDLE) begin
            c_write = req_write;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            commit  = accept && (WAIT_CYCLES == 0);
        end else if (state == WAIT) begin
            commit  = (wait_cnt == 4'd1);
        end
    end

    assign c_in_range = ({1'b0, c_addr} < NUM_REGS_L);

    always_comb begin
        c_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (c_addr == ADDR_W'(i)) begin
                c_rdata = regs[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_write <= req_write;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= !c_in_range;
                rsp_rdata <= (!c_write && c_in_range) ? c_rdata : '0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (c_write && c_in_range && c_addr == ADDR_W'(i)) begin
                        regs[i] <= c_wdata;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_reg_bank_slave.sv
// tb/tb_reg_bank_slave.sv - scoreboard bench for reg_bank_slave across three parameter sets
module tb_reg_bank_slave;

    logic       clk = 1'b0;
    logic       rstn;
    logic       req_valid [3];
    logic       req_ready [3];
    logic       req_write [3];
    logic [1:0] req_addr  [3];
    logic [7:0] req_wdata [3];
    logic       rsp_valid [3];
    logic       rsp_ready [3];
    logic [7:0] rsp_rdata [3];
    logic       rsp_err   [3];
    logic [31:0] reg_q_a;
    logic [23:0] reg_q_b;
    logic [31:0] reg_q_c;

    int errors = 0;
    int checks = 0;

    // Expected responses: {err, rdata}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    always #5 clk = ~clk;

    reg_bank_slave #(.DATA_W(8), .ADDR_W(2), .NUM_REGS(4), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .rstn(rstn), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .reg_q(reg_q_a)
    );

    reg_bank_slave #(.DATA_W(8), .ADDR_W(2), .NUM_REGS(3), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rstn(rstn), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .reg_q(reg_q_b)
    );

    reg_bank_slave #(.DATA_W(8), .ADDR_W(2), .NUM_REGS(4), .WAIT_CYCLES(3)) dut_c (
        .clk(clk), .rstn(rstn), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
        .rsp_err(rsp_err[2]), .reg_q(reg_q_c)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 3;
    endfunction

    task automatic push_exp(input int k, input logic [8:0] v);
        case (k)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rstn && rsp_valid[k] && rsp_ready[k]) begin
                logic [8:0] e;
                int sz;
                sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
                if (sz == 0) begin
                    chk($sformatf("unexpected rsp dut%0d", k), {rsp_err[k], rsp_rdata[k]}, 9'h1ff);
                end else begin
                    case (k)
                        0: e = q0.pop_front();
                        1: e = q1.pop_front();
                        default: e = q2.pop_front();
                    endcase
                    chk($sformatf("rsp dut%0d", k), {rsp_err[k], rsp_rdata[k]}, e);
                end
            end
        end
    end

    // Called and returns at posedge+1.
    task automatic xact(input int k, input logic wr, input logic [1:0] a, input logic [7:0] d,
                        input logic [7:0] exp_d, input logic exp_e, input int hold);
        int n;
        logic [7:0] first;
        rsp_ready[k] = (hold == 0);
        req_write[k] = wr;
        req_addr[k]  = a;
        req_wdata[k] = d;
        req_valid[k] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[k] && n < 20);
        if (!req_ready[k]) fail_now("accept");
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_wdata[k] = ~d;
        req_addr[k]  = ~a;
        push_exp(k, {exp_e, exp_d});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid[k] && n < 20);
        chk($sformatf("latency dut%0d", k), n, wait_of(k) + 1);
        if (hold > 0) begin
            first = rsp_rdata[k];
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                req_valid[k] = ~req_valid[k];
                req_write[k] = 1'b1;
                req_addr[k]  = 2'(i);
                req_wdata[k] = 8'hEE;
                @(negedge clk);
                chk("hold rsp_valid", rsp_valid[k], 1);
                chk("hold req_ready", req_ready[k], 0);
                chk("hold rsp_rdata", rsp_rdata[k], first);
            end
            @(posedge clk);
            #1;
            req_valid[k] = 1'b0;
            rsp_ready[k] = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("post rsp_valid", rsp_valid[k], 0);
            chk("post req_ready", req_ready[k], 1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k]  = 2'd0;
            req_wdata[k] = 8'd0;
            rsp_ready[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset rsp_valid", rsp_valid[0], 0);
        chk("reset req_ready", req_ready[0], 1);
        chk("reset reg_q_a", reg_q_a, 32'h0);
        chk("reset rsp_rdata", rsp_rdata[0], 0);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Default parameter set
        xact(0, 1, 2'd2, 8'hA5, 8'h00, 0, 0);
        chk("reg_q a[23:16]", reg_q_a[23:16], 8'hA5);
        xact(0, 0, 2'd2, 8'h00, 8'hA5, 0, 0);
        for (int a = 0; a < 4; a++) xact(0, 1, 2'(a), 8'(a * 4), 8'h00, 0, 0);
        for (int a = 0; a < 4; a++) xact(0, 0, 2'(a), 8'h00, 8'(a * 4), 0, 0);
        chk("reg_q a all", reg_q_a, 32'h0C080400);

        // Reset in the middle of a write's wait state
        req_write[0] = 1'b1;
        req_addr[0]  = 2'd1;
        req_wdata[0] = 8'h3C;
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("pre-reset req_ready", req_ready[0], 1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("async rsp_valid", rsp_valid[0], 0);
        chk("async rsp_rdata", rsp_rdata[0], 0);
        chk("async reg_q a[15:8]", reg_q_a[15:8], 8'h00);
        chk("async reg_q a", reg_q_a, 32'h0);
        chk("async req_ready", req_ready[0], 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;
        chk("release req_ready", req_ready[0], 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no rsp after reset", rsp_valid[0], 0);
        end
        @(posedge clk);
        #1;
        xact(0, 0, 2'd1, 8'h00, 8'h00, 0, 0);

        // Zero wait states, three registers
        xact(1, 1, 2'd1, 8'h5A, 8'h00, 0, 0);
        xact(1, 1, 2'd3, 8'hFF, 8'h00, 1, 0);
        chk("reg_q b", reg_q_b, 24'h005A00);
        xact(1, 0, 2'd3, 8'h00, 8'h00, 1, 0);
        xact(1, 0, 2'd1, 8'h00, 8'h5A, 0, 0);

        // Three wait states with response back-pressure
        xact(2, 1, 2'd0, 8'h77, 8'h00, 0, 5);
        xact(2, 0, 2'd0, 8'h00, 8'h77, 0, 0);
        chk("reg_q c", reg_q_c, 32'h00000077);

        repeat (3) @(posedge clk);
        chk("scoreboard drained", q0.size() + q1.size() + q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: bench did not complete");
        $fatal(1);
    end

endmodule
